absenc_slave: RTL and testbench
===============================

// Module: absenc_slave
// PURPOSE
// - Parametrised absolute-encoder slave transmitter: answers an external SSI or BiSS-C master
//   clock on clk_in_i with the current position on data_o. Sits in the encoder-output path
//   beside the quadrature generator.
// - Generalises the fixed 32-bit SSI/BiSS output: DATA_W-wide positions, runtime BITS, BiSS-C
//   ACK/START/CDS/nE/nW/CRC6 framing, programmable timeout, frame counter, protocol-error flag.
// PARAMETERS
// - DATA_W       32  position input width; max BITS
// - TMO_W        16  width of TIMEOUT register / timeout counter
// - SYNC_STAGES  2   synchroniser flops on clk_in_i (>=2)
// PORTS
// - clk_i        in   1        system clock
// - reset_n_i    in   1        asynchronous, active-low reset
// - enable_i     in   1        slave enable; low aborts any frame
// - posn_i       in   DATA_W   position, binary, latched at frame start
// - err_i        in   1        error flag, sent as nE (inverted) in BiSS
// - warn_i       in   1        warning flag, sent as nW (inverted) in BiSS
// - clk_in_i     in   1        master clock from pad (asynchronous)
// - data_o       out  1        serial data to pad
// - PROTOCOL     in   1        0 = SSI, 1 = BiSS-C; sampled at frame start
// - BITS         in   8        data bits per frame; 0 or >DATA_W clamps to DATA_W
// - TIMEOUT      in   TMO_W    clk_i cycles without a clk_in edge ending a frame (0 treated as 1)
// - busy_o       out  1        frame in progress (LATCH..TAIL)
// - frame_done_o out  1        1-cycle pulse on TAIL->IDLE
// - frame_cnt_o  out  32       completed frames, wraps 0xFFFFFFFF->0
// - proto_err_o  out  1        sticky: clk_in edge during TAIL; cleared while enable_i low
// BEHAVIOUR
// - Reset: data_o=0, busy_o=0, frame_done_o=0, frame_cnt_o=0, proto_err_o=0, state DISABLED.
// - clk_in_i through SYNC_STAGES flops, then 1-flop edge detect; data_o registered.
//   Latency clk_in_i edge -> data_o change = SYNC_STAGES+2 clk_i. Master half-period >= 8 clk_i.
// - States: DISABLED, IDLE, ACK, SHIFT, TAIL.
//   DISABLED: data_o=0; enable_i=1 -> IDLE. enable_i=0 in any state -> DISABLED next cycle.
//   IDLE: data_o=1. SSI: clk_in fall -> latch. BiSS: clk_in rise -> latch, data_o=0 (ACK).
//   Latch = posn_i masked to BITS LSBs, nE/nW, PROTOCOL and clamped BITS into shift regs.
//   SSI SHIFT: each clk_in rise drives next bit MSB first; after BITS bits -> TAIL.
//   BiSS: ACK held one rise; then per rise: START=1, CDS=0, BITS data MSB first, nE, nW,
//   6 CRC bits inverted MSB first -> TAIL.
//   CRC6 poly x^6+x+1 (0x43), init 0, over data+nE+nW, advanced as bits are driven.
//   TAIL: data_o=0; counter reloads TIMEOUT on each clk_in edge, decrements per clk_i;
//   at 0 -> IDLE, data_o=1, frame_done_o pulse, frame_cnt_o+1. Edge in TAIL also sets proto_err_o.
// - Edges not expected in current state (e.g. SSI rise in IDLE, fall in SHIFT) are ignored.
// - Reset mid-frame: all outputs to reset values immediately; no frame_done_o.
// - Config changes mid-frame have no effect until next latch.
// CONFIGURATION
// - ABSENC_GRAY_EN defined: extra input GRAY (1 bit); when 1, data field is binary-to-Gray of
//   the masked position (BiSS CRC covers the Gray bits). Undefined: no GRAY port, binary only.
// STRUCTURE
// - absenc_pkg: protocol enum (PROT_SSI, PROT_BISS), state enum, CRC6_POLY=6'h03 (x^6 implicit),
//   crc6_next() function, bin2gray() function.
// - One sub-module: absenc_crc6 (serial CRC6, clear/enable/bit inputs, 6-bit output).
// TESTING
// - SSI, BITS=8, posn_i=0xA5, TIMEOUT=50, 10-clk_i half-period -> data_o 1,0,1,0,0,1,0,1, then 0
//   for 50 cycles after last edge, then 1; frame_done_o pulse; frame_cnt_o=1.
// - BiSS, BITS=8, posn_i=0x3C, err_i=warn_i=0 -> 0,1,0,00111100,1,1, then ~CRC6 matching model; TAIL.
// - BITS=40, DATA_W=32, posn_i=0xFFFFFFFF -> exactly 32 ones before TAIL; BITS=0 identical.
// - Extra clk_in edges during TAIL -> data_o stays 0, timeout restarts, proto_err_o=1 until enable_i low.
// - reset_n_i low mid-SHIFT -> data_o=0, busy_o=0, frame_cnt_o=0 same cycle; no frame_done_o.
// - ABSENC_GRAY_EN, GRAY=1, SSI, BITS=4, posn_i=0x5 -> data bits 0,1,1,1.

Source files
------------

// File: rtl/absenc_pkg.sv
// ---------------------------------------------------------------------------
// absenc_pkg : shared types and helpers for the absolute-encoder slave
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package absenc_pkg;

  typedef enum logic {
    PROT_SSI  = 1'b0,
    PROT_BISS = 1'b1
  } prot_t;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ACK      = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_TAIL     = 3'd4
  } state_t;

  // Field currently being driven inside ST_SHIFT; FLD_END means the next rise enters TAIL
  typedef enum logic [2:0] {
    FLD_CDS  = 3'd0,
    FLD_DATA = 3'd1,
    FLD_NE   = 3'd2,
    FLD_NW   = 3'd3,
    FLD_CRC  = 3'd4,
    FLD_END  = 3'd5
  } field_t;

  localparam logic [5:0] CRC6_POLY = 6'h03;

  function automatic logic [5:0] crc6_next(input logic [5:0] crc, input logic din);
    logic fb;
    fb = crc[5] ^ din;
    return {crc[4:0], 1'b0} ^ (fb ? CRC6_POLY : 6'h00);
  endfunction

  function automatic logic [63:0] bin2gray(input logic [63:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/absenc_slave_crc6.sv
// ---------------------------------------------------------------------------
// absenc_crc6 : serial CRC6 (x^6+x+1), zero init, one bit per enabled cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module absenc_crc6 (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [5:0] crc_o
);
  import absenc_pkg::*;

  logic [5:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 6'h00;
    end else if (en_i) begin
      crc_d = crc6_next(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      crc_q <= 6'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/absenc_slave.sv
// ---------------------------------------------------------------------------
// absenc_slave : SSI / BiSS-C absolute-encoder slave transmitter
// Optional ABSENC_GRAY_EN adds a GRAY input selecting Gray-coded position data.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module absenc_slave #(
  parameter int DATA_W      = 32,
  parameter int TMO_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] posn_i,
  input  logic              err_i,
  input  logic              warn_i,
  input  logic              clk_in_i,
`ifdef ABSENC_GRAY_EN
  input  logic              GRAY,
`endif
  input  logic              PROTOCOL,
  input  logic [7:0]        BITS,
  input  logic [TMO_W-1:0]  TIMEOUT,
  output logic              data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [31:0]       frame_cnt_o,
  output logic              proto_err_o
);
  import absenc_pkg::*;

  localparam int IDX_W = ($clog2(DATA_W + 1) < 3) ? 3 : $clog2(DATA_W + 1);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic prev_d, prev_q, rise_d, rise_q, fall_d, fall_q;

  state_t            state_d, state_q;
  prot_t             proto_d, proto_q, proto_in;
  field_t            fld_d, fld_q;
  logic [IDX_W-1:0]  idx_d, idx_q, bits_eff;
  logic [DATA_W-1:0] shreg_d, shreg_q, masked, field_w, aligned;
  logic              ne_d, ne_q, nw_d, nw_q;
  logic [TMO_W-1:0]  tmo_d, tmo_q, tmo_load;
  logic              data_d, data_q, busy_d, busy_q, done_d, done_q, perr_d, perr_q;
  logic [31:0]       cnt_d, cnt_q;
  logic              crc_clr, crc_en, crc_bit;
  logic [5:0]        crc;

  assign proto_in = prot_t'(PROTOCOL);
  assign tmo_load = (TIMEOUT == '0) ? TMO_W'(1) : TIMEOUT;

  // Synchroniser plus registered edge pulses
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], clk_in_i};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  // Position field as it will be shifted: masked, optionally Gray, MSB left-aligned
  always_comb begin
    if (BITS == 8'd0 || 32'(BITS) > DATA_W) begin
      bits_eff = IDX_W'(DATA_W);
    end else begin
      bits_eff = IDX_W'(BITS);
    end
    masked  = posn_i & ({DATA_W{1'b1}} >> (DATA_W - int'(bits_eff)));
    field_w = masked;
`ifdef ABSENC_GRAY_EN
    if (GRAY) begin
      field_w = DATA_W'(bin2gray(64'(masked)));
    end
`endif
    aligned = field_w << (DATA_W - int'(bits_eff));
  end

  absenc_crc6 u_crc6 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (crc_clr),
    .en_i      (crc_en),
    .bit_i     (crc_bit),
    .crc_o     (crc)
  );

  always_comb begin
    state_d = state_q;
    proto_d = proto_q;
    fld_d   = fld_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    ne_d    = ne_q;
    nw_d    = nw_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    cnt_d   = cnt_q;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_bit = shreg_q[DATA_W-1];

    if (!enable_i) begin
      state_d = ST_DISABLED;
      data_d  = 1'b0;
      busy_d  = 1'b0;
      perr_d  = 1'b0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d = ST_IDLE;
          data_d  = 1'b1;
        end
        ST_IDLE: begin
          data_d = 1'b1;
          if ((proto_in == PROT_SSI && fall_q) || (proto_in == PROT_BISS && rise_q)) begin
            proto_d = proto_in;
            shreg_d = aligned;
            ne_d    = ~err_i;
            nw_d    = ~warn_i;
            idx_d   = bits_eff - IDX_W'(1);
            busy_d  = 1'b1;
            crc_clr = 1'b1;
            if (proto_in == PROT_BISS) begin
              state_d = ST_ACK;
              fld_d   = FLD_CDS;
              data_d  = 1'b0;
            end else begin
              state_d = ST_SHIFT;
              fld_d   = FLD_DATA;
            end
          end
        end
        ST_ACK: begin
          if (rise_q) begin
            state_d = ST_SHIFT;
            data_d  = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (rise_q) begin
            case (fld_q)
              FLD_CDS: begin
                data_d = 1'b0;
                fld_d  = FLD_DATA;
              end
              FLD_DATA: begin
                data_d  = shreg_q[DATA_W-1];
                shreg_d = shreg_q << 1;
                crc_en  = 1'b1;
                if (idx_q == '0) begin
                  if (proto_q == PROT_BISS) fld_d = FLD_NE;
                  else                      fld_d = FLD_END;
                end else begin
                  idx_d = idx_q - IDX_W'(1);
                end
              end
              FLD_NE: begin
                data_d  = ne_q;
                crc_en  = 1'b1;
                crc_bit = ne_q;
                fld_d   = FLD_NW;
              end
              FLD_NW: begin
                data_d  = nw_q;
                crc_en  = 1'b1;
                crc_bit = nw_q;
                fld_d   = FLD_CRC;
                idx_d   = IDX_W'(5);
              end
              FLD_CRC: begin
                data_d = ~crc[idx_q[2:0]];
                if (idx_q == '0) fld_d = FLD_END;
                else             idx_d = idx_q - IDX_W'(1);
              end
              default: begin
                state_d = ST_TAIL;
                data_d  = 1'b0;
                tmo_d   = tmo_load;
              end
            endcase
          end
        end
        ST_TAIL: begin
          data_d = 1'b0;
          if (rise_q || fall_q) begin
            tmo_d  = tmo_load;
            perr_d = 1'b1;
          end else if (tmo_q <= TMO_W'(1)) begin
            state_d = ST_IDLE;
            data_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 32'd1;
          end else begin
            tmo_d = tmo_q - TMO_W'(1);
          end
        end
        default: begin
          state_d = ST_DISABLED;
          data_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Synchroniser resets high: both protocols idle the master clock high, so no false edge
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      state_q <= ST_DISABLED;
      proto_q <= PROT_SSI;
      fld_q   <= FLD_END;
      idx_q   <= '0;
      shreg_q <= '0;
      ne_q    <= 1'b0;
      nw_q    <= 1'b0;
      tmo_q   <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      state_q <= state_d;
      proto_q <= proto_d;
      fld_q   <= fld_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      ne_q    <= ne_d;
      nw_q    <= nw_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o       = data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign frame_cnt_o  = cnt_q;
  assign proto_err_o  = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_absenc_slave.sv
// ---------------------------------------------------------------------------
// tb_absenc_slave : randomized self-checking bench for absenc_slave
// Define ABSENC_GRAY_EN to include the Gray-coding case. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_absenc_slave;

  localparam int DATA_W      = 32;
  localparam int TMO_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HP          = 10;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              enable_i;
  logic [DATA_W-1:0] posn_i;
  logic              err_i;
  logic              warn_i;
  logic              clk_in_i;
`ifdef ABSENC_GRAY_EN
  logic              GRAY;
`endif
  logic              PROTOCOL;
  logic [7:0]        BITS;
  logic [TMO_W-1:0]  TIMEOUT;
  logic              data_o;
  logic              busy_o;
  logic              frame_done_o;
  logic [31:0]       frame_cnt_o;
  logic              proto_err_o;

  absenc_slave #(.DATA_W(DATA_W), .TMO_W(TMO_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .enable_i     (enable_i),
    .posn_i       (posn_i),
    .err_i        (err_i),
    .warn_i       (warn_i),
    .clk_in_i     (clk_in_i),
`ifdef ABSENC_GRAY_EN
    .GRAY         (GRAY),
`endif
    .PROTOCOL     (PROTOCOL),
    .BITS         (BITS),
    .TIMEOUT      (TIMEOUT),
    .data_o       (data_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .frame_cnt_o  (frame_cnt_o),
    .proto_err_o  (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_cnt  = 0;
  bit          exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic rise();
    clk_in_i = 1'b1;
    wait_clks(HP);
  endtask

  task automatic fall();
    clk_in_i = 1'b0;
    wait_clks(HP);
  endtask

  // CRC as polynomial remainder of msg(x)*x^6 modulo x^6+x+1
  function automatic logic [5:0] ref_crc(input logic [63:0] msg, input int len);
    logic [63:0] v;
    v = msg << 6;
    for (int i = len + 5; i >= 6; i--) begin
      if (v[i]) v = v ^ (64'h43 << (i - 6));
    end
    return v[5:0];
  endfunction

  // Expected data_o after each master rise, ACK included for BiSS
  task automatic build_frame(input bit biss, input int bits_in, input logic [31:0] posn,
                             input bit err, input bit warn, input bit gray);
    int          b;
    logic [31:0] m;
    logic [63:0] msg;
    logic [5:0]  c;
    b = (bits_in == 0 || bits_in > DATA_W) ? DATA_W : bits_in;
    m = (b == 32) ? posn : (posn & ((32'd1 << b) - 32'd1));
    if (gray) m = m ^ (m >> 1);
    exp_q.delete();
    if (biss) begin
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
    end
    for (int i = b - 1; i >= 0; i--) exp_q.push_back(m[i]);
    if (biss) begin
      msg = {32'd0, m};
      msg = (msg << 2) | {62'd0, ~err, ~warn};
      c = ref_crc(msg, b + 2);
      exp_q.push_back(~err);
      exp_q.push_back(~warn);
      for (int i = 5; i >= 0; i--) exp_q.push_back(~c[i]);
    end
  endtask

  // Called right after the edge that (re)starts the timeout
  task automatic tail_measure(input string tag, input int tmo);
    int want;
    int n;
    want = (tmo == 0) ? 1 : tmo;
    wait_clks(SYNC_STAGES + 2);
    n = 0;
    while (data_o === 1'b0 && n < want + 50) begin
      n++;
      @(negedge clk_i);
    end
    chk({tag, "_tail_len"}, 64'(n), 64'(want));
    chk({tag, "_done"}, frame_done_o, 1);
    exp_cnt++;
    chk({tag, "_cnt"}, frame_cnt_o, exp_cnt);
    @(negedge clk_i);
    chk({tag, "_done_clr"}, frame_done_o, 0);
    chk({tag, "_idle_after"}, {busy_o, data_o}, 2'b01);
  endtask

  task automatic run_frame(input bit biss, input int bits_in, input logic [31:0] posn,
                           input bit err, input bit warn, input bit gray, input int tmo,
                           input bit scramble, input int extra, input string tag);
    PROTOCOL = biss;
    BITS     = 8'(bits_in);
    posn_i   = posn;
    err_i    = err;
    warn_i   = warn;
    TIMEOUT  = TMO_W'(tmo);
`ifdef ABSENC_GRAY_EN
    GRAY     = gray;
`endif
    build_frame(biss, bits_in, posn, err, warn, gray);
    wait_clks(2);
    chk({tag, "_idle"}, {busy_o, data_o}, 2'b01);
    if (!biss) fall();
    foreach (exp_q[i]) begin
      if (biss) fall();
      rise();
      chk($sformatf("%s_bit%0d", tag, i), data_o, exp_q[i]);
      if (i == 0) begin
        chk({tag, "_busy"}, busy_o, 1);
        if (scramble) begin
          posn_i   = $urandom;
          BITS     = 8'($urandom);
          PROTOCOL = ~PROTOCOL;
          err_i    = ~err_i;
          warn_i   = ~warn_i;
          TIMEOUT  = TMO_W'($urandom_range(1, 60));
        end
      end
      if (!biss) fall();
    end
    if (biss) fall();
    TIMEOUT  = TMO_W'(tmo);
    clk_in_i = 1'b1;
    for (int e = 0; e < extra; e++) begin
      wait_clks(HP);
      chk({tag, "_tail_low"}, data_o, 0);
      if (e > 0) chk({tag, "_perr_set"}, proto_err_o, 1);
      clk_in_i = ~clk_in_i;
    end
    tail_measure(tag, tmo);
    chk({tag, "_perr"}, proto_err_o, (extra > 0) ? 1 : 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    reset_n_i = 1'b0;
    enable_i  = 1'b0;
    clk_in_i  = 1'b1;
    posn_i    = '0;
    err_i     = 1'b0;
    warn_i    = 1'b0;
    PROTOCOL  = 1'b0;
    BITS      = 8'd8;
    TIMEOUT   = TMO_W'(50);
`ifdef ABSENC_GRAY_EN
    GRAY      = 1'b0;
`endif
    wait_clks(3);
    chk("reset_outs", {data_o, busy_o, frame_done_o, proto_err_o}, 4'b0000);
    chk("reset_cnt", frame_cnt_o, 0);
    reset_n_i = 1'b1;
    wait_clks(3);
    chk("disabled_data", data_o, 0);
    enable_i = 1'b1;
    wait_clks(3);
    chk("enabled_idle", data_o, 1);

    run_frame(1'b0, 8,  32'hA5,       1'b0, 1'b0, 1'b0, 50, 1'b0, 0, "ssi_a5");
    run_frame(1'b1, 8,  32'h3C,       1'b0, 1'b0, 1'b0, 20, 1'b0, 0, "biss_3c");
    run_frame(1'b0, 40, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 12, 1'b0, 0, "ssi_b40");
    run_frame(1'b0, 0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 12, 1'b0, 0, "ssi_b0");
    run_frame(1'b1, 40, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 9,  1'b0, 0, "biss_b40");
    run_frame(1'b0, 5,  32'h0000001B, 1'b0, 1'b0, 1'b0, 0,  1'b0, 0, "ssi_tmo0");

    for (int r = 0; r < 12; r++) begin
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 45)), $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                int'($urandom_range(1, 40)), 1'b1, 0, $sformatf("rnd%0d", r));
    end

`ifdef ABSENC_GRAY_EN
    run_frame(1'b0, 4, 32'h5, 1'b0, 1'b0, 1'b1, 10, 1'b0, 0, "gray_ssi");
    run_frame(1'b1, 12, $urandom, 1'b0, 1'b1, 1'b1, 10, 1'b0, 0, "gray_biss");
`endif

    // Extra master edges during TAIL
    run_frame(1'b0, 4, 32'h9, 1'b0, 1'b0, 1'b0, 30, 1'b0, 2, "tail_edges");
    wait_clks(5);
    chk("perr_sticky", proto_err_o, 1);
    enable_i = 1'b0;
    wait_clks(2);
    chk("perr_cleared", {proto_err_o, data_o, busy_o}, 3'b000);
    enable_i = 1'b1;
    wait_clks(2);
    chk("reenable_idle", data_o, 1);

    // Reset in the middle of SHIFT
    PROTOCOL = 1'b0;
    BITS     = 8'd16;
    posn_i   = 32'hFFFF;
    TIMEOUT  = TMO_W'(5);
    wait_clks(2);
    fall();
    rise();
    rise();
    fall();
    rise();
    chk("pre_reset_busy", busy_o, 1);
    reset_n_i = 1'b0;
    #1;
    chk("rst_mid_outs", {data_o, busy_o, frame_done_o, proto_err_o}, 4'b0000);
    chk("rst_mid_cnt", frame_cnt_o, 0);
    exp_cnt   = 0;
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      seen_done = seen_done | frame_done_o;
    end
    reset_n_i = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      seen_done = seen_done | frame_done_o;
    end
    chk("rst_no_done", seen_done, 0);
    chk("rst_idle", {busy_o, data_o}, 2'b01);
    run_frame(1'b1, 6, 32'h2A, 1'b1, 1'b0, 1'b0, 7, 1'b0, 0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
